// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port VRAM shared by the Z80 bus and a video burst fetcher
module vram_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8,
    parameter int BURST  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_ce,
    input  logic              cpu_oce,
    input  logic              cpu_wre,
    input  logic              cpu_iorq,
    input  logic [ADDR_W-1:0] cpu_ad,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_dout_en,
    output logic              cpu_wait,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_ad,
    output logic              vid_ack,
    output logic              vid_valid,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_last
);
    typedef enum logic [1:0] {IDLE, VID, CPU_RD} state_t;

    state_t            state;
    logic              served;
    logic              fair;
    logic [3:0]        beat;
    logic [ADDR_W-1:0] vid_base;
    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] ram_q;
    logic              cpu_req;
    logic              vid_go;
    logic              cpu_go;
    logic              ram_we;
    logic              ram_re;
    logic              vid_rd;
    logic              vid_rd_last;
    logic [ADDR_W-1:0] ram_addr;

    assign cpu_req     = cpu_ce & ~cpu_iorq & ~served;
    assign cpu_wait    = cpu_req;
    assign cpu_dout_en = cpu_ce & cpu_oce & ~cpu_wre & ~cpu_iorq & served;
    // a pending CPU access left over from the previous burst beats a new video request
    assign vid_go      = (state == IDLE) & vid_req & ~(fair & cpu_req) & ~reset;
    assign cpu_go      = (state == IDLE) & ~vid_go & cpu_req & ~reset;
    assign vid_ack     = vid_go;
    assign vid_data    = ram_q;

    // RAM port steering: video start, video continuation, or CPU access
    always_comb begin
        vid_rd      = vid_go | (state == VID);
        ram_we      = cpu_go & cpu_wre;
        ram_re      = vid_rd | (cpu_go & ~cpu_wre);
        ram_addr    = vid_go ? vid_ad : (state == VID) ? vid_base + ADDR_W'(beat) : cpu_ad;
        vid_rd_last = vid_go ? (BURST == 1) : (state == VID) & (beat == 4'(BURST - 1));
    end

    // RAM write port; contents survive reset
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= cpu_din;
    end

    // synchronous read register, shared by the video stream and CPU capture
    always_ff @(posedge clk) begin
        if (reset) ram_q <= '0;
        else if (ram_re) ram_q <= mem[ram_addr];
    end

    // arbitration FSM with CPU service and fairness bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            served   <= 1'b0;
            fair     <= 1'b0;
            beat     <= '0;
            cpu_dout <= '0;
            vid_base <= '0;
        end else begin
            if (!cpu_ce) served <= 1'b0;
            case (state)
                IDLE: begin
                    if (vid_go) begin
                        vid_base <= vid_ad;
                        beat     <= 4'd1;
                        state    <= (BURST == 1) ? IDLE : VID;
                    end else if (cpu_go && cpu_wre) begin
                        served <= 1'b1;
                        fair   <= 1'b0;
                    end else if (cpu_go) begin
                        state <= CPU_RD;
                    end
                end
                VID: begin
                    beat <= beat + 4'd1;
                    if (beat == 4'(BURST - 1)) begin
                        state <= IDLE;
                        fair  <= cpu_req;
                    end
                end
                CPU_RD: begin
                    cpu_dout <= ram_q;
                    served   <= 1'b1;
                    fair     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // video beat qualifiers trail each video read by one cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            vid_valid <= 1'b0;
            vid_last  <= 1'b0;
        end else begin
            vid_valid <= vid_rd;
            vid_last  <= vid_rd_last;
        end
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard bench for vram_arbiter with BURST=2 and BURST=4 instances
module tb_vram_arbiter;
    typedef struct {
        int         c;
        logic [7:0] d;
        logic       l;
    } beat_t;

    logic        clk = 0;
    logic        reset;
    logic        cpu_ce, cpu_oce, cpu_wre, cpu_iorq;
    logic [12:0] cpu_ad, vid_ad;
    logic [7:0]  cpu_din;
    logic        vid_req2, vid_req4;
    logic [7:0]  cpu_dout2, cpu_dout4, vid_data2, vid_data4;
    logic        dout_en2, dout_en4, wait2, wait4;
    logic        ack2, ack4, valid2, valid4, last2, last4;
    int          cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        prev_en = 0;
    beat_t       q2[$];
    beat_t       q4[$];
    logic [7:0]  cq[$];

    vram_arbiter #(.ADDR_W(13), .DATA_W(8), .BURST(2)) u2 (
        .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_oce(cpu_oce), .cpu_wre(cpu_wre),
        .cpu_iorq(cpu_iorq), .cpu_ad(cpu_ad), .cpu_din(cpu_din), .cpu_dout(cpu_dout2),
        .cpu_dout_en(dout_en2), .cpu_wait(wait2), .vid_req(vid_req2), .vid_ad(vid_ad),
        .vid_ack(ack2), .vid_valid(valid2), .vid_data(vid_data2), .vid_last(last2)
    );

    vram_arbiter #(.ADDR_W(13), .DATA_W(8), .BURST(4)) u4 (
        .clk(clk), .reset(reset), .cpu_ce(cpu_ce), .cpu_oce(cpu_oce), .cpu_wre(cpu_wre),
        .cpu_iorq(cpu_iorq), .cpu_ad(cpu_ad), .cpu_din(cpu_din), .cpu_dout(cpu_dout4),
        .cpu_dout_en(dout_en4), .cpu_wait(wait4), .vid_req(vid_req4), .vid_ad(vid_ad),
        .vid_ack(ack4), .vid_valid(valid4), .vid_data(vid_data4), .vid_last(last4)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic mon_vid(input int sel, input logic v, input logic l, input logic [7:0] d);
        beat_t e;
        int    n;
        if (l && !v) begin
            tests++;
            fails++;
            $display("FAIL dut%0d last_without_valid at cycle %0d", sel, cyc);
        end
        if (v) begin
            tests++;
            n = (sel == 0) ? q2.size() : q4.size();
            if (n == 0) begin
                fails++;
                $display("FAIL dut%0d unexpected_beat data %0h last %0b at cycle %0d", sel, d, l, cyc);
            end else begin
                if (sel == 0) e = q2.pop_front();
                else e = q4.pop_front();
                if (e.c != cyc || e.d !== d || e.l !== l) begin
                    fails++;
                    $display("FAIL dut%0d vid_beat: got cycle %0d data %0h last %0b expected cycle %0d data %0h last %0b",
                             sel, cyc, d, l, e.c, e.d, e.l);
                end
            end
        end
    endtask

    // monitor: compares every presented video beat and CPU read result against the queues
    always @(negedge clk) begin
        mon_vid(0, valid2, last2, vid_data2);
        mon_vid(1, valid4, last4, vid_data4);
        if (dout_en2 && !prev_en) begin
            tests++;
            if (cq.size() == 0) begin
                fails++;
                $display("FAIL unexpected_cpu_read data %0h at cycle %0d", cpu_dout2, cyc);
            end else begin
                logic [7:0] e;
                e = cq.pop_front();
                if (cpu_dout2 !== e) begin
                    fails++;
                    $display("FAIL cpu_dout: got %0h expected %0h", cpu_dout2, e);
                end
            end
        end
        prev_en = dout_en2;
    end

    task automatic cpu_access(input logic wr, input logic [12:0] a, input logic [7:0] d, input int exp_wait);
        int n;
        n = 0;
        cpu_ad = a;
        cpu_din = d;
        cpu_wre = wr;
        cpu_oce = !wr;
        cpu_ce = 1;
        if (!wr) cq.push_back(d);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!wait2) break;
            n++;
        end
        check(wr ? "wr_wait_cycles" : "rd_wait_cycles", n, exp_wait);
        if (!wr) check("rd_dout_en", {31'b0, dout_en2}, 1);
        @(posedge clk);
        #1;
        cpu_ce = 0;
        cpu_oce = 0;
        cpu_wre = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic vid_burst(input int sel, input logic [12:0] a, input int nb, input int blen, input logic [63:0] exp);
        int   t;
        logic seen;
        vid_ad = a;
        if (sel == 0) vid_req2 = 1;
        else vid_req4 = 1;
        for (int b = 0; b < nb; b++) begin
            seen = 0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(negedge clk);
                seen = (sel == 0) ? ack2 : ack4;
            end
            tests++;
            if (!seen) begin
                fails++;
                $display("FAIL dut%0d ack_timeout: got no ack expected ack within 30 cycles", sel);
            end else begin
                t = cyc;
                for (int i = 0; i < blen; i++) begin
                    if (sel == 0) q2.push_back('{t + 1 + i, exp[8*i+:8], i == blen - 1});
                    else q4.push_back('{t + 1 + i, exp[8*i+:8], i == blen - 1});
                end
            end
            @(posedge clk);
            #1;
            if (b == nb - 1) begin
                vid_req2 = 0;
                vid_req4 = 0;
            end
        end
    endtask

    initial begin
        reset = 1;
        cpu_ce = 0;
        cpu_oce = 0;
        cpu_wre = 0;
        cpu_iorq = 0;
        cpu_ad = 0;
        cpu_din = 0;
        vid_ad = 0;
        vid_req2 = 0;
        vid_req4 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cpu_dout", cpu_dout2, 0);
        check("rst_dout_en", {31'b0, dout_en2}, 0);
        check("rst_vid_valid", {30'b0, valid2, valid4}, 0);
        check("rst_vid_last", {30'b0, last2, last4}, 0);
        check("rst_vid_data", {16'b0, vid_data2, vid_data4}, 0);
        check("rst_wait_ack", {28'b0, wait2, wait4, ack2, ack4}, 0);
        @(posedge clk);
        #1;
        reset = 0;
        @(posedge clk);
        #1;

        cpu_access(1, 13'h1234, 8'hA5, 1);
        cpu_access(0, 13'h1234, 8'hA5, 2);
        cpu_access(1, 13'h0000, 8'h11, 1);
        cpu_access(1, 13'h0001, 8'h22, 1);
        cpu_access(1, 13'h0002, 8'h33, 1);
        cpu_access(1, 13'h0003, 8'h44, 1);
        cpu_access(1, 13'h1FFF, 8'h77, 1);

        vid_burst(0, 13'h0001, 1, 2, 64'h3322);
        repeat (4) @(posedge clk);
        #1;
        vid_burst(0, 13'h1FFF, 1, 2, 64'h1177);
        repeat (4) @(posedge clk);
        #1;

        fork
            cpu_access(0, 13'h1234, 8'hA5, 4);
            vid_burst(0, 13'h0002, 2, 2, 64'h4433);
        join
        repeat (4) @(posedge clk);
        #1;

        cpu_iorq = 1;
        cpu_ce = 1;
        cpu_wre = 1;
        cpu_oce = 1;
        cpu_ad = 13'h0000;
        cpu_din = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("iorq_wait", {31'b0, wait2}, 0);
            check("iorq_dout_en", {31'b0, dout_en2}, 0);
        end
        @(posedge clk);
        #1;
        cpu_iorq = 0;
        cpu_ce = 0;
        cpu_wre = 0;
        cpu_oce = 0;
        @(posedge clk);
        #1;
        cpu_access(0, 13'h0000, 8'h11, 2);

        vid_ad = 13'h0000;
        vid_req4 = 1;
        @(negedge clk);
        check("rst_burst_ack", {31'b0, ack4}, 1);
        q4.push_back('{cyc + 1, 8'h11, 1'b0});
        @(posedge clk);
        #1;
        vid_req4 = 0;
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("post_reset_valid", {31'b0, valid4}, 0);
        end
        @(posedge clk);
        #1;
        vid_burst(1, 13'h0000, 1, 4, 64'h44332211);
        repeat (8) @(posedge clk);
        #1;

        check("q2_drained", q2.size(), 0);
        check("q4_drained", q4.size(), 0);
        check("cq_drained", cq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
